// File: rtl/iob2axil.sv
// IOb slave to AXI4-Lite master bridge, one outstanding transaction.
// Read data returns on a one-cycle iob_rvalid_o pulse; err_o flags a non-OKAY response.
module iob2axil #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]          axil_awprot_o,
  output logic                axil_awvalid_o,
  input  logic                axil_awready_i,
  output logic [DATA_W-1:0]   axil_wdata_o,
  output logic [DATA_W/8-1:0] axil_wstrb_o,
  output logic                axil_wvalid_o,
  input  logic                axil_wready_i,
  input  logic [1:0]          axil_bresp_i,
  input  logic                axil_bvalid_i,
  output logic                axil_bready_o,
  output logic [ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]          axil_arprot_o,
  output logic                axil_arvalid_o,
  input  logic                axil_arready_i,
  input  logic [DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]          axil_rresp_i,
  input  logic                axil_rvalid_i,
  output logic                axil_rready_o
);

  typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic aw_hs, w_hs, b_hs;

  assign axil_awvalid_o = (state_q == WR) && !aw_done_q;
  assign axil_wvalid_o  = (state_q == WR) && !w_done_q;
  assign axil_bready_o  = (state_q == WR) || (state_q == WAIT_B);
  assign axil_arvalid_o = (state_q == RD);
  assign axil_rready_o  = (state_q == WAIT_R);

  assign axil_awaddr_o = addr_q;
  assign axil_araddr_o = addr_q;
  assign axil_awprot_o = 3'b000;
  assign axil_arprot_o = 3'b000;
  assign axil_wdata_o  = wdata_q;
  assign axil_wstrb_o  = wstrb_q;

  assign iob_ready_o  = ready_q;
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;
  assign err_o        = err_q;

  assign aw_hs = axil_awvalid_o && axil_awready_i;
  assign w_hs  = axil_wvalid_o && axil_wready_i;
  assign b_hs  = axil_bvalid_i && axil_bready_o;

  always_comb begin
    state_d   = state_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      IDLE: begin
        if (iob_avalid_i && ready_q) begin
          addr_d    = iob_addr_i;
          wdata_d   = iob_wdata_i;
          wstrb_d   = iob_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (|iob_wstrb_i) ? WR : RD;
        end
      end
      WR: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        // B may land in the same cycle as the last address/data beat
        if (aw_done_d && w_done_d) begin
          if (b_hs) begin
            state_d = IDLE;
            err_d   = |axil_bresp_i;
          end else begin
            state_d = WAIT_B;
          end
        end
      end
      WAIT_B: begin
        if (axil_bvalid_i) begin
          state_d = IDLE;
          err_d   = |axil_bresp_i;
        end
      end
      RD: begin
        if (axil_arready_i) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (axil_rvalid_i) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = axil_rdata_i;
          err_d    = |axil_rresp_i;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_iob2axil.sv
// Bench for iob2axil: directed and randomized IOb transactions against a TB-side
// AXI-Lite slave, with a byte-level reference memory predicting read data.
module tb_iob2axil;

  localparam int LIM = 40;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        cke_i;
  logic        iob_avalid_i;
  logic [31:0] iob_addr_i;
  logic [31:0] iob_wdata_i;
  logic [3:0]  iob_wstrb_i;
  logic        iob_ready_o;
  logic        iob_rvalid_o;
  logic [31:0] iob_rdata_o;
  logic        err_o;
  logic [31:0] axil_awaddr_o;
  logic [2:0]  axil_awprot_o;
  logic        axil_awvalid_o;
  logic        axil_awready_i;
  logic [31:0] axil_wdata_o;
  logic [3:0]  axil_wstrb_o;
  logic        axil_wvalid_o;
  logic        axil_wready_i;
  logic [1:0]  axil_bresp_i;
  logic        axil_bvalid_i;
  logic        axil_bready_o;
  logic [31:0] axil_araddr_o;
  logic [2:0]  axil_arprot_o;
  logic        axil_arvalid_o;
  logic        axil_arready_i;
  logic [31:0] axil_rdata_i;
  logic [1:0]  axil_rresp_i;
  logic        axil_rvalid_i;
  logic        axil_rready_o;

  iob2axil #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i),
    .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
    .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
    .iob_rdata_o(iob_rdata_o), .err_o(err_o),
    .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o),
    .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(axil_awready_i),
    .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
    .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i),
    .axil_bresp_i(axil_bresp_i), .axil_bvalid_i(axil_bvalid_i),
    .axil_bready_o(axil_bready_o),
    .axil_araddr_o(axil_araddr_o), .axil_arprot_o(axil_arprot_o),
    .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
    .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i),
    .axil_rvalid_i(axil_rvalid_i), .axil_rready_o(axil_rready_o)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Reference memory follows what the IOb master asked for; slave memory follows the AXI bus.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] slv_get(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int bd, input logic [1:0] resp);
    int aw_cnt, w_cnt, awv, wv, both_k, b_k, ready_k, mx;
    aw_cnt = 0; w_cnt = 0; awv = 0; wv = 0; both_k = -1; b_k = -1; ready_k = -1;
    mx = (awd > wd) ? awd : wd;
    chk("wr_ready_before", 64'(iob_ready_o), 64'(1));
    iob_avalid_i = 1'b1; iob_addr_i = a; iob_wdata_i = d; iob_wstrb_i = s;
    tick();
    iob_avalid_i = 1'b0;
    ref_mem[a] = merge(ref_get(a), d, s);
    for (int k = 0; k < LIM; k++) begin
      if (iob_ready_o) begin ready_k = k; break; end
      axil_awready_i = (k >= awd);
      axil_wready_i  = (k >= wd);
      axil_bvalid_i  = (both_k >= 0) && (b_k < 0) && (k >= both_k + 1 + bd);
      axil_bresp_i   = resp;
      if (k == 0) begin
        chk("wr_awvalid_first", 64'(axil_awvalid_o), 64'(1));
        chk("wr_wvalid_first", 64'(axil_wvalid_o), 64'(1));
        chk("wr_awaddr", 64'(axil_awaddr_o), 64'(a));
        chk("wr_wdata", 64'(axil_wdata_o), 64'(d));
        chk("wr_wstrb", 64'(axil_wstrb_o), 64'(s));
        chk("wr_awprot", 64'(axil_awprot_o), 64'(0));
        chk("wr_arvalid_idle", 64'(axil_arvalid_o), 64'(0));
      end
      if (axil_awvalid_o) awv++;
      if (axil_wvalid_o) wv++;
      if (axil_awvalid_o && axil_awready_i) aw_cnt++;
      if (axil_wvalid_o && axil_wready_i) begin
        w_cnt++;
        slv_mem[axil_awaddr_o] = merge(slv_get(axil_awaddr_o), axil_wdata_o, axil_wstrb_o);
      end
      if (axil_bvalid_i && axil_bready_o) b_k = k;
      if (both_k < 0 && aw_cnt > 0 && w_cnt > 0) both_k = k;
      tick();
    end
    axil_awready_i = 1'b0; axil_wready_i = 1'b0; axil_bvalid_i = 1'b0;
    chk("wr_ready_latency", 64'(ready_k), 64'(mx + 2 + bd));
    chk("wr_err", 64'(err_o), 64'(resp != 2'b00));
    chk("wr_aw_beats", 64'(aw_cnt), 64'(1));
    chk("wr_w_beats", 64'(w_cnt), 64'(1));
    chk("wr_awvalid_cycles", 64'(awv), 64'(awd + 1));
    chk("wr_wvalid_cycles", 64'(wv), 64'(wd + 1));
    chk("wr_valids_done", 64'({axil_awvalid_o, axil_wvalid_o, axil_bready_o}), 64'(0));
    tick();
    chk("wr_err_pulse_end", 64'(err_o), 64'(0));
    chk("wr_ready_hold", 64'(iob_ready_o), 64'(1));
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, input int rd,
                         input logic [1:0] resp);
    int ar_cnt, arv, ar_k, r_k, done_k;
    logic [31:0] exp_d;
    ar_cnt = 0; arv = 0; ar_k = -1; r_k = -1; done_k = -1;
    exp_d = ref_get(a);
    chk("rd_ready_before", 64'(iob_ready_o), 64'(1));
    iob_avalid_i = 1'b1; iob_addr_i = a; iob_wdata_i = $urandom; iob_wstrb_i = 4'h0;
    tick();
    iob_avalid_i = 1'b0;
    for (int k = 0; k < LIM; k++) begin
      if (iob_rvalid_o || iob_ready_o) begin done_k = k; break; end
      axil_arready_i = (k >= ard);
      axil_rvalid_i  = (ar_k >= 0) && (r_k < 0) && (k >= ar_k + 1 + rd);
      axil_rdata_i   = axil_rvalid_i ? slv_get(a) : $urandom;
      axil_rresp_i   = resp;
      if (k == 0) begin
        chk("rd_arvalid_first", 64'(axil_arvalid_o), 64'(1));
        chk("rd_araddr", 64'(axil_araddr_o), 64'(a));
        chk("rd_arprot", 64'(axil_arprot_o), 64'(0));
        chk("rd_no_write", 64'({axil_awvalid_o, axil_wvalid_o}), 64'(0));
      end
      if (axil_arvalid_o) arv++;
      if (axil_arvalid_o && axil_arready_i) begin ar_cnt++; ar_k = k; end
      if (axil_rvalid_i && axil_rready_o) r_k = k;
      tick();
    end
    axil_arready_i = 1'b0; axil_rvalid_i = 1'b0;
    chk("rd_latency", 64'(done_k), 64'(ard + rd + 2));
    chk("rd_rvalid", 64'(iob_rvalid_o), 64'(1));
    chk("rd_rdata", 64'(iob_rdata_o), 64'(exp_d));
    chk("rd_err", 64'(err_o), 64'(resp != 2'b00));
    chk("rd_ready_with_rvalid", 64'(iob_ready_o), 64'(1));
    chk("rd_ar_beats", 64'(ar_cnt), 64'(1));
    chk("rd_arvalid_cycles", 64'(arv), 64'(ard + 1));
    chk("rd_chan_idle", 64'({axil_arvalid_o, axil_rready_o}), 64'(0));
    tick();
    chk("rd_rvalid_pulse_end", 64'(iob_rvalid_o), 64'(0));
    chk("rd_err_pulse_end", 64'(err_o), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  r;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    arst_n_i = 1'b0; cke_i = 1'b1;
    iob_avalid_i = 1'b0; iob_addr_i = '0; iob_wdata_i = '0; iob_wstrb_i = '0;
    axil_awready_i = 1'b0; axil_wready_i = 1'b0; axil_bresp_i = 2'b00; axil_bvalid_i = 1'b0;
    axil_arready_i = 1'b0; axil_rdata_i = '0; axil_rresp_i = 2'b00; axil_rvalid_i = 1'b0;

    // Reset, then idle
    #2;
    chk("rst_outputs", 64'({iob_ready_o, iob_rvalid_o, err_o, axil_awvalid_o, axil_wvalid_o,
                            axil_bready_o, axil_arvalid_o, axil_rready_o}), 64'(0));
    chk("rst_rdata", 64'(iob_rdata_o), 64'(0));
    tick();
    tick();
    chk("rst_ready_held", 64'(iob_ready_o), 64'(0));
    arst_n_i = 1'b1;
    chk("rel_ready_before_edge", 64'(iob_ready_o), 64'(0));
    tick();
    chk("rel_ready_first_edge", 64'(iob_ready_o), 64'(1));
    chk("rel_no_axi_valid", 64'({axil_awvalid_o, axil_wvalid_o, axil_arvalid_o}), 64'(0));

    // Directed writes and reads
    do_write(32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00);
    do_write(32'h0000_1008, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 2'b00);
    do_read(32'h0000_1004, 0, 0, 2'b00);
    ref_mem[32'h0000_2000] = 32'h1234_5678;
    slv_mem[32'h0000_2000] = 32'h1234_5678;
    do_read(32'h0000_2000, 0, 2, 2'b00);
    chk("rd_2000_const", 64'(ref_get(32'h0000_2000)), 64'(32'h1234_5678));
    do_read(32'h0000_1008, 1, 0, 2'b10);
    do_write(32'h0000_1004, 32'h0000_AA00, 4'b0010, 0, 2, 1, 2'b11);
    do_read(32'h0000_1004, 0, 0, 2'b00);

    // Reset while waiting for read data
    iob_avalid_i = 1'b1; iob_addr_i = 32'h0000_3000; iob_wstrb_i = 4'h0;
    tick();
    iob_avalid_i = 1'b0;
    chk("rst_rd_arvalid", 64'(axil_arvalid_o), 64'(1));
    axil_arready_i = 1'b1;
    tick();
    axil_arready_i = 1'b0;
    chk("rst_rd_rready", 64'(axil_rready_o), 64'(1));
    #2;
    arst_n_i = 1'b0;
    #1;
    chk("rst_mid_drop", 64'({axil_rready_o, axil_arvalid_o, iob_ready_o, axil_bready_o,
                             iob_rvalid_o}), 64'(0));
    tick();
    arst_n_i = 1'b1;
    tick();
    chk("rst_mid_idle", 64'({iob_ready_o, axil_rready_o, axil_arvalid_o}), 64'(3'b100));

    // Clock-enable stall in the middle of a write
    iob_avalid_i = 1'b1; iob_addr_i = 32'h0000_4000; iob_wdata_i = 32'h5566_7788;
    iob_wstrb_i = 4'b0011;
    tick();
    iob_avalid_i = 1'b0;
    ref_mem[32'h0000_4000] = merge(ref_get(32'h0000_4000), 32'h5566_7788, 4'b0011);
    cke_i = 1'b0; axil_awready_i = 1'b1; axil_wready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cke_stall_valids", 64'({axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_ready_o}),
          64'(4'b1110));
    end
    cke_i = 1'b1;
    cap_wdata = axil_wdata_o; cap_wstrb = axil_wstrb_o;
    slv_mem[32'h0000_4000] = merge(slv_get(axil_awaddr_o), cap_wdata, cap_wstrb);
    tick();
    axil_awready_i = 1'b0; axil_wready_i = 1'b0;
    chk("cke_after_hs", 64'({axil_awvalid_o, axil_wvalid_o, axil_bready_o}), 64'(3'b001));
    axil_bvalid_i = 1'b1; axil_bresp_i = 2'b00;
    tick();
    axil_bvalid_i = 1'b0;
    chk("cke_wr_done", 64'({iob_ready_o, err_o}), 64'(2'b10));
    do_read(32'h0000_4000, 0, 1, 2'b00);

    // Randomized traffic over a small address window
    for (int n = 0; n < 40; n++) begin
      a = 32'h0000_0100 + 32'(4 * $urandom_range(0, 7));
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
      end else begin
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iob2axil.md
# iob2axil

Bridge converting a single-outstanding IOb-bus slave port into an AXI4-Lite master port. It lets IOb-native masters (boot controller, DMA-less peripherals, debug units) reach AXI-side targets such as the internal `axi_ram` or the external memory port through the system `axi_interconnect`. It complements the existing AXI-Lite→IOb peripheral bridge, covering the opposite direction. It issues exactly one AXI transaction per accepted IOb request and returns read data on the IOb `rvalid` pulse.

## Interface
- `ADDR_W`, 32: address width on both sides.
- `DATA_W`, 32: data width on both sides; `DATA_W/8` strobe bits.

- `clk_i`  in  1  system clock; all logic on the rising edge.
- `arst_n_i`  in  1  asynchronous, active-low reset.
- `cke_i`  in  1  clock enable; when low, all state and outputs hold.
- `iob_avalid_i`  in  1  request valid.
- `iob_addr_i`  in  ADDR_W  byte address.
- `iob_wdata_i`  in  DATA_W  write data.
- `iob_wstrb_i`  in  DATA_W/8  write strobes; a nonzero value means write, zero means read.
- `iob_ready_o`  out  1  bridge can accept a request this cycle.
- `iob_rvalid_o`  out  1  one-cycle read-data valid pulse.
- `iob_rdata_o`  out  DATA_W  read data, valid while `iob_rvalid_o` is high.
- `err_o`  out  1  one-cycle pulse when the completed transaction returned `xRESP != 2'b00`.
- `axil_aw{addr,prot,valid}_o` / `axil_awready_i`: AXI-Lite write address channel.
- `axil_w{data,strb,valid}_o` / `axil_wready_i`: AXI-Lite write data channel.
- `axil_b{resp,valid}_i` / `axil_bready_o`: AXI-Lite write response channel.
- `axil_ar{addr,prot,valid}_o` / `axil_arready_i`: AXI-Lite read address channel.
- `axil_r{data,resp,valid}_i` / `axil_rready_o`: AXI-Lite read data channel.

## Operation
- FSM states: IDLE, WR (AW/W outstanding), WAIT_B, RD (AR outstanding), WAIT_R.
- `iob_ready_o` is registered and high only in IDLE. A request is accepted when `iob_avalid_i & iob_ready_o & cke_i`. While `iob_ready_o` is low, `iob_avalid_i` is ignored; the master holds the request.
- On accept, the bridge registers addr, wdata and wstrb, then drops `iob_ready_o`.
  - Nonzero wstrb: go to WR.
  - Zero wstrb: go to RD.
- WR:
  - `awvalid` and `wvalid` assert together.
  - Each one deasserts independently on its own handshake (`valid & ready`). Two flags track completion.
  - When both handshakes are done (same or different cycles), go to WAIT_B.
  - `bready` is high in both WR and WAIT_B.
  - If a B handshake occurs in the same cycle as the last AW/W handshake, go straight to IDLE.
- WAIT_B: on `bvalid`, sample `bresp` and go to IDLE.
- RD: `arvalid` is high; on `arready`, go to WAIT_R.
- WAIT_R:
  - `rready` is high.
  - On `rvalid`, register `rdata` into `iob_rdata_o`, pulse `iob_rvalid_o`, and go to IDLE.
- `awprot` and `arprot` are constant `3'b000`.
- `awaddr` and `araddr` equal the registered address unmodified. `wdata` and `wstrb` equal the registered values.
- Error handling:
  - `err_o` pulses in the cycle completion is signalled whenever `resp != OKAY`.
  - Read data is still delivered on an error.
  - No retry.
- Reset values:
  - `iob_ready_o`, `iob_rvalid_o`, `err_o` and all AXI valid/ready outputs are 0.
  - `iob_rdata_o` and the address/data registers are 0.
  - The FSM is in IDLE.
- Reset asserted mid-transaction drops every output to its reset value immediately (asynchronous reset). The in-flight AXI transaction is abandoned; the system resets the interconnect at the same time.
- `cke_i` low freezes the FSM, the registers and all outputs. Handshakes are not counted while `cke_i` is low.

## Timing
- `iob_ready_o` rises on the first enabled edge after reset release.
- Write with zero-wait AXI, request accepted at edge T:
  - `awvalid`/`wvalid` high in cycle T+1, handshake at T+1.
  - `bvalid` high no earlier than T+2.
  - `iob_ready_o` high in the cycle after the B handshake (earliest T+3).
- Read, accepted at T:
  - `arvalid` high in cycle T+1.
  - `rvalid` arrives at T+2 at the earliest.
  - `iob_rvalid_o` and `iob_rdata_o` valid at T+3, with `iob_ready_o` high in the same cycle.
- A new request may be accepted in the same cycle as `iob_rvalid_o`.
- `iob_rvalid_o` lasts exactly 1 cycle. No AXI valid drops before its handshake.

## Test plan
- Reset then idle: all outputs 0 during reset; `iob_ready_o=1` one edge after release, no AXI valid asserted.
- Write 0x0000_1004 ← 0xDEADBEEF with wstrb 0xF, zero-wait slave, bresp OKAY:
  - `awaddr=0x1004`, `wdata=0xDEADBEEF`, `wstrb=0xF` for exactly 1 cycle.
  - `iob_ready_o` back at T+3, `err_o=0`.
- Write with awready delayed 3 cycles and wready immediate:
  - `wvalid` drops after 1 cycle while `awvalid` holds 4 cycles.
  - Single B completes the write; no duplicate W beat.
- Read 0x0000_2000, slave returns `rdata=0x12345678` after 2-cycle latency: exactly one `iob_rvalid_o` pulse with `iob_rdata_o=0x12345678`.
- Read with `rresp=2'b10`: `iob_rvalid_o` and `err_o` pulse together with the returned data.
- Assert `arst_n_i` low while in WAIT_R, then `cke_i` low for 5 cycles mid-write:
  - Reset: `rready`/`arvalid` drop immediately and the FSM returns to IDLE.
  - Clock-enable stall: the FSM state, and `awvalid`/`wvalid`, stay unchanged throughout the stall.
